// File: rtl/ps2_voice_scheduler.sv
// Four-slot polyphonic voice allocator fed by PS/2 scan codes from the receiver FIFO.
// Decodes make/break/extended sequences and steals the oldest voice when all slots are busy.
module ps2_voice_scheduler (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ready,
    input  logic [7:0]  data,
    output logic        nextdata_n,
    output logic [3:0]  voice_on,
    output logic [31:0] voice_key,
    output logic [63:0] voice_inc,
    output logic [2:0]  nvoices,
    output logic        steal
);

    typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

    state_t      state, state_nx;
    logic [7:0]  byte_q;
    logic        brk, ext, brk_nx, ext_nx;
    logic [3:0]  on_nx;
    logic [7:0]  key_q [4];
    logic [7:0]  key_nx [4];
    logic [15:0] inc_q [4];
    logic [15:0] inc_nx [4];
    logic [1:0]  age_q [4];
    logic [1:0]  age_nx [4];
    logic        steal_nx;
    logic [2:0]  cnt_nx;
    logic        hit, free;
    logic [1:0]  hit_idx, free_idx, oldest_idx, tgt;
    logic [2:0]  prev_age;
    logic [15:0] byte_inc;

    function automatic logic [15:0] note_inc(input logic [7:0] k);
        case (k)
            8'h1C:   note_inc = 16'd714;
            8'h1B:   note_inc = 16'd802;
            8'h23:   note_inc = 16'd900;
            8'h2B:   note_inc = 16'd954;
            8'h34:   note_inc = 16'd1070;
            8'h33:   note_inc = 16'd1201;
            8'h3B:   note_inc = 16'd1349;
            8'h42:   note_inc = 16'd1429;
            default: note_inc = 16'd0;
        endcase
    endfunction

    always_comb begin
        state_nx = state;
        brk_nx   = brk;
        ext_nx   = ext;
        on_nx    = voice_on;
        key_nx   = key_q;
        inc_nx   = inc_q;
        age_nx   = age_q;
        steal_nx = 1'b0;
        hit      = 1'b0;
        hit_idx  = 2'd0;
        free     = 1'b0;
        free_idx = 2'd0;
        oldest_idx = 2'd0;
        tgt      = 2'd0;
        prev_age = 3'd4;
        byte_inc = note_inc(byte_q);

        // Descending scan so the lowest-index free slot wins.
        for (int i = 3; i >= 0; i--) begin
            if (voice_on[i] && key_q[i] == byte_q) begin
                hit     = 1'b1;
                hit_idx = 2'(i);
            end
            if (!voice_on[i]) begin
                free     = 1'b1;
                free_idx = 2'(i);
            end
            if (voice_on[i] && age_q[i] == 2'd3) oldest_idx = 2'(i);
        end

        case (state)
            IDLE: if (ready) state_nx = POP;
            POP: begin
                state_nx = GAP;
                if (byte_q == 8'hF0) begin
                    brk_nx = 1'b1;
                end else if (byte_q == 8'hE0) begin
                    ext_nx = 1'b1;
                end else begin
                    brk_nx = 1'b0;
                    ext_nx = 1'b0;
                    if (!ext && byte_inc != 16'd0) begin
                        if (brk) begin
                            if (hit) begin
                                for (int i = 0; i < 4; i++)
                                    if (voice_on[i] && age_q[i] > age_q[hit_idx])
                                        age_nx[i] = age_q[i] - 2'd1;
                                on_nx[hit_idx]  = 1'b0;
                                key_nx[hit_idx] = 8'h00;
                                inc_nx[hit_idx] = 16'd0;
                                age_nx[hit_idx] = 2'd0;
                            end
                        end else if (!hit) begin
                            if (free) begin
                                tgt      = free_idx;
                                prev_age = 3'd4;
                            end else begin
                                tgt      = oldest_idx;
                                prev_age = 3'd3;
                                steal_nx = 1'b1;
                            end
                            for (int i = 0; i < 4; i++)
                                if (voice_on[i] && 2'(i) != tgt && {1'b0, age_q[i]} < prev_age)
                                    age_nx[i] = age_q[i] + 2'd1;
                            on_nx[tgt]  = 1'b1;
                            key_nx[tgt] = byte_q;
                            inc_nx[tgt] = byte_inc;
                            age_nx[tgt] = 2'd0;
                        end
                    end
                end
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        cnt_nx = 3'd0;
        for (int i = 0; i < 4; i++) cnt_nx = cnt_nx + {2'b00, on_nx[i]};
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            byte_q     <= 8'h00;
            brk        <= 1'b0;
            ext        <= 1'b0;
            nextdata_n <= 1'b1;
            voice_on   <= 4'b0000;
            nvoices    <= 3'd0;
            steal      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                key_q[i] <= 8'h00;
                inc_q[i] <= 16'd0;
                age_q[i] <= 2'd0;
            end
        end else begin
            state      <= state_nx;
            if (state == IDLE && ready) byte_q <= data;
            brk        <= brk_nx;
            ext        <= ext_nx;
            nextdata_n <= (state_nx != POP);
            voice_on   <= on_nx;
            nvoices    <= cnt_nx;
            steal      <= steal_nx;
            key_q      <= key_nx;
            inc_q      <= inc_nx;
            age_q      <= age_nx;
        end
    end

    always_comb begin
        voice_key = '0;
        voice_inc = '0;
        for (int i = 0; i < 4; i++) begin
            voice_key[8*i +: 8]   = key_q[i];
            voice_inc[16*i +: 16] = inc_q[i];
        end
    end

endmodule

// File: tb/tb_ps2_voice_scheduler.sv
// Self-checking bench for ps2_voice_scheduler: directed test-plan sequences plus random
// byte streams, compared against a slot/age-order reference model.
module tb_ps2_voice_scheduler;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        nextdata_n;
    logic [3:0]  voice_on;
    logic [31:0] voice_key;
    logic [63:0] voice_inc;
    logic [2:0]  nvoices;
    logic        steal;

    int checks = 0;
    int failures = 0;
    int since_low = 99;
    int steal_count = 0;

    // Reference model: slot contents plus a recency list (newest first), so a slot's
    // age is its position in the list and the oldest voice is the list tail.
    logic [7:0] m_key [4];
    logic       m_on [4];
    int         order [$];
    logic       m_brk, m_ext, m_steal;

    ps2_voice_scheduler dut (
        .clk(clk), .clrn(clrn), .ready(ready), .data(data),
        .nextdata_n(nextdata_n), .voice_on(voice_on), .voice_key(voice_key),
        .voice_inc(voice_inc), .nvoices(nvoices), .steal(steal)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pop strobe must be single-cycle and at least three clocks apart.
    always @(negedge clk) begin
        if (!clrn) since_low = 99;
        else if (!nextdata_n) begin
            check_output("ndn_spacing", {63'd0, since_low >= 3}, 64'd1);
            since_low = 1;
        end else since_low++;
    end

    function automatic logic [15:0] ref_inc(input logic [7:0] k);
        case (k)
            8'h1C: return 16'd714;
            8'h1B: return 16'd802;
            8'h23: return 16'd900;
            8'h2B: return 16'd954;
            8'h34: return 16'd1070;
            8'h33: return 16'd1201;
            8'h3B: return 16'd1349;
            8'h42: return 16'd1429;
            default: return 16'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_key[i] = 8'h00;
            m_on[i] = 1'b0;
        end
        order.delete();
        m_brk = 1'b0;
        m_ext = 1'b0;
        m_steal = 1'b0;
    endtask

    task automatic drop_from_order(input int s);
        for (int j = 0; j < order.size(); j++)
            if (order[j] == s) begin
                order.delete(j);
                break;
            end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int s;
        m_steal = 1'b0;
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            if (!m_ext && ref_inc(b) != 16'd0) begin
                s = -1;
                for (int i = 0; i < 4; i++) if (m_on[i] && m_key[i] == b) s = i;
                if (m_brk) begin
                    if (s >= 0) begin
                        m_on[s] = 1'b0;
                        m_key[s] = 8'h00;
                        drop_from_order(s);
                    end
                end else if (s < 0) begin
                    for (int i = 3; i >= 0; i--) if (!m_on[i]) s = i;
                    if (s < 0) begin
                        s = order[order.size()-1];
                        m_steal = 1'b1;
                    end
                    drop_from_order(s);
                    order.push_front(s);
                    m_on[s] = 1'b1;
                    m_key[s] = b;
                end
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic compare_voices(input string tag);
        logic [3:0]  e_on;
        logic [31:0] e_key;
        logic [63:0] e_inc;
        for (int i = 0; i < 4; i++) begin
            e_on[i] = m_on[i];
            e_key[8*i +: 8] = m_key[i];
            e_inc[16*i +: 16] = m_on[i] ? ref_inc(m_key[i]) : 16'd0;
        end
        check_output({tag, ".on"}, {60'd0, voice_on}, {60'd0, e_on});
        check_output({tag, ".key"}, {32'd0, voice_key}, {32'd0, e_key});
        check_output({tag, ".inc"}, voice_inc, e_inc);
        check_output({tag, ".nvoices"}, {61'd0, nvoices}, 64'(order.size()));
        check_output({tag, ".steal"}, {63'd0, steal}, {63'd0, m_steal});
    endtask

    // Offer one byte at a negedge, emulate the FIFO pop, then check during GAP.
    task automatic apply_stimulus(input logic [7:0] b);
        bit popped = 0;
        ready = 1'b1;
        data = b;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (!nextdata_n) begin
                popped = 1;
                break;
            end
        end
        check_output("pop_seen", {63'd0, popped}, 64'd1);
        ready = 1'b0;
        data = 8'($urandom);
        model_byte(b);
        @(negedge clk);
        check_output("gap_ndn", {63'd0, nextdata_n}, 64'd1);
        if (steal) steal_count++;
        compare_voices("byte");
    endtask

    task automatic do_reset();
        ready = 1'b0;
        clrn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] pool [12];
        pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42,
                 8'hF0, 8'hE0, 8'h15, 8'h1A};
        model_reset();
        @(negedge clk);
        check_output("rst.ndn", {63'd0, nextdata_n}, 64'd1);
        compare_voices("rst");
        do_reset();

        $display("[TB] make then break 1C");
        apply_stimulus(8'h1C);
        check_output("t1.inc0", {48'd0, voice_inc[15:0]}, 64'd714);
        apply_stimulus(8'hF0);
        apply_stimulus(8'h1C);
        check_output("t1.empty", {60'd0, voice_on}, 64'd0);

        $display("[TB] fill four slots then steal");
        do_reset();
        apply_stimulus(8'h1C);
        apply_stimulus(8'h1B);
        apply_stimulus(8'h23);
        apply_stimulus(8'h2B);
        steal_count = 0;
        apply_stimulus(8'h34);
        check_output("t2.key0", {56'd0, voice_key[7:0]}, 64'h34);
        check_output("t2.inc0", {48'd0, voice_inc[15:0]}, 64'd1070);
        check_output("t2.steal", {63'd0, steal}, 64'd1);
        @(negedge clk);
        check_output("t2.steal_pulse", {63'd0, steal}, 64'd0);

        $display("[TB] reuse lowest free slot");
        do_reset();
        apply_stimulus(8'h1C);
        apply_stimulus(8'h1B);
        apply_stimulus(8'hF0);
        apply_stimulus(8'h1C);
        apply_stimulus(8'h33);
        check_output("t3.inc0", {48'd0, voice_inc[15:0]}, 64'd1201);
        check_output("t3.key1", {56'd0, voice_key[15:8]}, 64'h1B);

        $display("[TB] typematic repeat");
        do_reset();
        steal_count = 0;
        for (int i = 0; i < 5; i++) apply_stimulus(8'h23);
        check_output("t4.nvoices", {61'd0, nvoices}, 64'd1);
        check_output("t4.steals", 64'(steal_count), 64'd0);

        $display("[TB] ignored codes");
        do_reset();
        apply_stimulus(8'hE0); apply_stimulus(8'h1C);
        apply_stimulus(8'hE0); apply_stimulus(8'hF0); apply_stimulus(8'h1C);
        apply_stimulus(8'h15);
        apply_stimulus(8'hF0); apply_stimulus(8'h42);
        check_output("t5.none", {60'd0, voice_on}, 64'd0);
        apply_stimulus(8'h42);
        check_output("t5.inc0", {48'd0, voice_inc[15:0]}, 64'd1429);

        $display("[TB] reset between prefix and code");
        do_reset();
        apply_stimulus(8'hF0);
        ready = 1'b1;
        data = 8'h1C;
        clrn = 1'b0;
        @(negedge clk);
        check_output("t6.ndn_in_reset", {63'd0, nextdata_n}, 64'd1);
        @(negedge clk);
        check_output("t6.ndn_in_reset2", {63'd0, nextdata_n}, 64'd1);
        ready = 1'b0;
        clrn = 1'b1;
        model_reset();
        @(negedge clk);
        apply_stimulus(8'h1C);
        check_output("t6.on", {60'd0, voice_on}, 64'd1);

        $display("[TB] random byte stream");
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(negedge clk);
            apply_stimulus(pool[$urandom_range(0, 11)]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_voice_scheduler.md
# ps2_voice_scheduler

Polyphonic voice allocator between the PS/2 scan-code receiver and the tone generators. It pops bytes from the receiver FIFO with the ready/nextdata_n handshake and decodes make, break (F0) and extended (E0) sequences. Note keys are assigned to one of four voice slots, and the oldest voice is stolen when all four are busy. Each slot drives one sine-table phase accumulator and its two-digit hex display.

## Interface
- NV, 4, number of voice slots (fixed; age logic sized for 4)
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- ready  in  1  receiver FIFO non-empty
- data  in  8  receiver FIFO head byte, valid while ready=1
- nextdata_n  out  1  active-low pop strobe to receiver; exactly one clk cycle low per consumed byte
- voice_on  out  4  slot i sounding
- voice_key  out  32  slot i scan code at [8i+7:8i]; 8'h00 when slot free
- voice_inc  out  64  slot i phase increment at [16i+15:16i]; 16'd0 when slot free
- nvoices  out  3  count of set bits in voice_on (0..4)
- steal  out  1  one-cycle pulse when an allocation evicted a held note

## Operation
- Handshake FSM, states IDLE, POP, GAP:
  - IDLE: if ready=1, latch data, go to POP.
  - POP: nextdata_n=0, process latched byte, go to GAP.
  - GAP: nextdata_n=1; gives receiver one cycle to update; go to IDLE.
  - Max throughput: 1 byte per 3 clocks. ready is ignored outside IDLE.
- Prefix flags brk (set by F0) and ext (set by E0):
  - F0 or E0 byte: set the flag, no voice change.
  - Any other byte is a code byte. Action: ext=1 -> ignore; else brk=1 -> break; else -> make. Both flags then clear.
- Note table (others are non-note and ignored for make and break), scan code -> inc:
  - 1C -> 714, 1B -> 802, 23 -> 900, 2B -> 954
  - 34 -> 1070, 33 -> 1201, 3B -> 1349, 42 -> 1429
  - inc = round(f*65536/48000).
- Make of note code K:
  - Already held in an active slot (typematic repeat): no change.
  - Else if a free slot exists: take the lowest-index free slot.
  - Else: steal the slot with age 3 and pulse steal.
  - Target slot gets key=K, inc=table(K), on=1, age=0. Every other active slot with age below the target's previous age (all active slots when the slot was free) increments its age.
- Break of code K: the slot holding K is freed (on=0, key=0, inc=0). Active slots with age greater than the freed slot's age decrement. No match -> no change.
- Age invariant: the ages of active slots are always the distinct values 0..nvoices-1.

## Timing
- Reset (async, clrn=0): FSM=IDLE, nextdata_n=1, brk=ext=0, voice_on=0, voice_key=0, voice_inc=0, all ages=0, nvoices=0, steal=0.
- Reset asserted mid-sequence: the pending byte and any prefix are discarded. The receiver FIFO is not popped.
- Voice outputs, nvoices and steal update on the clk edge ending POP, so they are visible during GAP. Latency from ready sampled in IDLE to output: 2 clocks.
- steal is high exactly during GAP of the stealing event.
- Outputs are registered; no combinational path from data/ready to outputs.
- nextdata_n is registered and low only in POP.

## Test plan
- Reset then bytes 1C, F0 1C -> after 1C: voice_on=0001, voice_key[7:0]=1C, voice_inc[15:0]=714, nvoices=1. After F0 1C: all zero. nextdata_n pulses low once per byte, each pulse one cycle wide and at least 3 clocks apart.
- Make 1C,1B,23,2B then 34 -> first four fill slots 0..3. 34 steals slot 0 (1C, oldest): key[7:0]=34, inc=1070, steal pulses once, nvoices stays 4.
- Make 1C,1B; break 1C; make 33 -> 33 lands in slot 0 (lowest free) with inc=1201. Slot 1 keeps 1B.
- Typematic: make 23 five times -> one slot only, nvoices=1, steal never asserted.
- Ignored codes: E0 1C, E0 F0 1C, make 15 (non-note), break 42 while not held -> no voice changes. Following make 42 -> slot 0, inc=1429.
- Assert clrn low between F0 and its code byte, then release and send 1C -> treated as a make (slot 0 on). No stale break.
